// File: rtl/tcp_axi4_master.sv
// tcp_axi4_master: converts TCP-side read/write commands into AXI4 INCR bursts.
// A command is split into bursts no longer than MAX_BURST beats that never
// cross a 4 KB page. One burst is outstanding at a time. W and R data pass
// straight through with no added latency. One aggregated response (the
// highest AXI resp code seen) is returned per command.
module tcp_axi4_master #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    // TCP command
    input  logic                    tcpBus_cmd_valid,
    output logic                    tcpBus_cmd_ready,
    input  logic                    tcpBus_cmd_write,
    input  logic [ADDR_WIDTH-1:0]   tcpBus_cmd_addr,
    input  logic [31:0]             tcpBus_cmd_size,
    // TCP write data
    input  logic                    tcpBus_wdata_valid,
    output logic                    tcpBus_wdata_ready,
    input  logic [DATA_WIDTH-1:0]   tcpBus_wdata_payload_fragment,
    input  logic                    tcpBus_wdata_payload_last,
    // TCP read data
    output logic                    tcpBus_rdata_valid,
    input  logic                    tcpBus_rdata_ready,
    output logic [DATA_WIDTH-1:0]   tcpBus_rdata_payload_fragment,
    output logic                    tcpBus_rdata_payload_last,
    // TCP response
    output logic                    tcpBus_rsp_valid,
    input  logic                    tcpBus_rsp_ready,
    output logic [1:0]              tcpBus_rsp_payload,
    // AXI write address
    output logic                    masterAxi_aw_valid,
    input  logic                    masterAxi_aw_ready,
    output logic [ADDR_WIDTH-1:0]   masterAxi_aw_addr,
    output logic [7:0]              masterAxi_aw_len,
    output logic [2:0]              masterAxi_aw_size,
    output logic [1:0]              masterAxi_aw_burst,
    // AXI write data
    output logic                    masterAxi_w_valid,
    input  logic                    masterAxi_w_ready,
    output logic [DATA_WIDTH-1:0]   masterAxi_w_data,
    output logic [DATA_WIDTH/8-1:0] masterAxi_w_strb,
    output logic                    masterAxi_w_last,
    // AXI write response
    input  logic                    masterAxi_b_valid,
    output logic                    masterAxi_b_ready,
    input  logic [1:0]              masterAxi_b_resp,
    // AXI read address
    output logic                    masterAxi_ar_valid,
    input  logic                    masterAxi_ar_ready,
    output logic [ADDR_WIDTH-1:0]   masterAxi_ar_addr,
    output logic [7:0]              masterAxi_ar_len,
    output logic [2:0]              masterAxi_ar_size,
    output logic [1:0]              masterAxi_ar_burst,
    // AXI read data
    input  logic                    masterAxi_r_valid,
    output logic                    masterAxi_r_ready,
    input  logic [DATA_WIDTH-1:0]   masterAxi_r_data,
    input  logic [1:0]              masterAxi_r_resp,
    input  logic                    masterAxi_r_last
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LOG2B = $clog2(BYTES);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             remaining_q, remaining_d;
    logic [8:0]              n_q, n_d;
    logic [7:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [8:0]              beat_cnt_q, beat_cnt_d;
    logic [1:0]              resp_q, resp_d;

    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [31:0]             next_rem;
    logic                    last_beat;
    logic                    unused_wdata_last;

    // Beats in the next burst: limited by what is left, MAX_BURST and the 4 KB page.
    function automatic logic [8:0] calc_beats(input logic [11:0] page_off, input logic [31:0] rem);
        logic [31:0] room;
        logic [31:0] lim;
        room = (32'd4096 - {20'd0, page_off}) >> LOG2B;
        lim  = rem;
        if (lim > 32'(MAX_BURST)) lim = 32'(MAX_BURST);
        if (lim > room) lim = room;
        return 9'(lim);
    endfunction

    // Higher AXI resp code wins (OKAY < EXOKAY < SLVERR < DECERR).
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (b > a) ? b : a;
    endfunction

    assign next_addr         = addr_q + (ADDR_WIDTH'(n_q) << LOG2B);
    assign next_rem          = remaining_q - 32'(n_q);
    assign last_beat         = (beat_cnt_q == n_q - 9'd1);
    assign unused_wdata_last = tcpBus_wdata_payload_last;

    // Next-state and datapath-register computation for the command sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        n_d         = n_q;
        len_d       = len_q;
        size_d      = size_q;
        beat_cnt_d  = beat_cnt_q;
        resp_d      = resp_q;
        case (state_q)
            IDLE: begin
                if (tcpBus_cmd_valid && tcpBus_cmd_ready) begin
                    addr_d      = tcpBus_cmd_addr & ~ADDR_WIDTH'(BYTES - 1);
                    remaining_d = tcpBus_cmd_size >> LOG2B;
                    resp_d      = 2'b00;
                    size_d      = 3'(LOG2B);
                    if (remaining_d == 32'd0) begin
                        state_d = RESP;
                    end else begin
                        n_d     = calc_beats(addr_d[11:0], remaining_d);
                        len_d   = 8'(n_d - 9'd1);
                        state_d = tcpBus_cmd_write ? WR_ADDR : RD_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                if (masterAxi_aw_ready) begin
                    beat_cnt_d = 9'd0;
                    state_d    = WR_DATA;
                end
            end
            WR_DATA: begin
                if (tcpBus_wdata_valid && masterAxi_w_ready) begin
                    if (last_beat) state_d = WR_RESP;
                    else           beat_cnt_d = beat_cnt_q + 9'd1;
                end
            end
            WR_RESP: begin
                if (masterAxi_b_valid) begin
                    resp_d      = resp_max(resp_q, masterAxi_b_resp);
                    addr_d      = next_addr;
                    remaining_d = next_rem;
                    if (next_rem != 32'd0) begin
                        n_d     = calc_beats(next_addr[11:0], next_rem);
                        len_d   = 8'(n_d - 9'd1);
                        state_d = WR_ADDR;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RD_ADDR: begin
                if (masterAxi_ar_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (masterAxi_r_valid && tcpBus_rdata_ready) begin
                    resp_d = resp_max(resp_q, masterAxi_r_resp);
                    if (masterAxi_r_last) begin
                        addr_d      = next_addr;
                        remaining_d = next_rem;
                        if (next_rem != 32'd0) begin
                            n_d     = calc_beats(next_addr[11:0], next_rem);
                            len_d   = 8'(n_d - 9'd1);
                            state_d = RD_ADDR;
                        end else begin
                            state_d = RESP;
                        end
                    end
                end
            end
            RESP: begin
                if (tcpBus_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and burst registers; reset abandons any in-flight AXI transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            n_q         <= '0;
            len_q       <= '0;
            size_q      <= '0;
            beat_cnt_q  <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            n_q         <= n_d;
            len_q       <= len_d;
            size_q      <= size_d;
            beat_cnt_q  <= beat_cnt_d;
            resp_q      <= resp_d;
        end
    end

    // cmd_ready is held low while reset is asserted so it only rises once reset is released.
    assign tcpBus_cmd_ready   = (state_q == IDLE) && !reset;

    assign masterAxi_aw_valid = (state_q == WR_ADDR);
    assign masterAxi_aw_addr  = addr_q;
    assign masterAxi_aw_len   = len_q;
    assign masterAxi_aw_size  = size_q;
    assign masterAxi_aw_burst = 2'b01;

    assign masterAxi_w_valid  = (state_q == WR_DATA) && tcpBus_wdata_valid;
    assign tcpBus_wdata_ready = (state_q == WR_DATA) && masterAxi_w_ready;
    assign masterAxi_w_data   = tcpBus_wdata_payload_fragment;
    assign masterAxi_w_strb   = '1;
    assign masterAxi_w_last   = (state_q == WR_DATA) && last_beat;

    assign masterAxi_b_ready  = (state_q == WR_RESP);

    assign masterAxi_ar_valid = (state_q == RD_ADDR);
    assign masterAxi_ar_addr  = addr_q;
    assign masterAxi_ar_len   = len_q;
    assign masterAxi_ar_size  = size_q;
    assign masterAxi_ar_burst = 2'b01;

    assign tcpBus_rdata_valid            = (state_q == RD_DATA) && masterAxi_r_valid;
    assign masterAxi_r_ready             = (state_q == RD_DATA) && tcpBus_rdata_ready;
    assign tcpBus_rdata_payload_fragment = masterAxi_r_data;
    assign tcpBus_rdata_payload_last     = (state_q == RD_DATA) && masterAxi_r_last &&
                                           (remaining_q == 32'(n_q));

    assign tcpBus_rsp_valid   = (state_q == RESP);
    assign tcpBus_rsp_payload = resp_q;

endmodule

// File: tb/tb_tcp_axi4_master.sv
// Testbench for tcp_axi4_master: reference model plans each command into
// expected bursts, beats and response; monitor compares what the DUT shows.
module tb_tcp_axi4_master;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int MB = 16;

    typedef struct packed { logic [31:0] addr; logic [7:0] len; } burst_t;
    typedef struct packed { logic [127:0] data; logic last; } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0]   cmd_addr = '0, cmd_size = '0;
    logic          wdata_valid = 1'b0, wdata_ready, wdata_last = 1'b0;
    logic [127:0]  wdata_frag = '0;
    logic          rdata_valid, rdata_ready = 1'b0, rdata_last;
    logic [127:0]  rdata_frag;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [1:0]    rsp_payload;
    logic          aw_valid, aw_ready = 1'b0;
    logic [31:0]   aw_addr;
    logic [7:0]    aw_len;
    logic [2:0]    aw_size;
    logic [1:0]    aw_burst;
    logic          w_valid, w_ready = 1'b0, w_last;
    logic [127:0]  w_data;
    logic [15:0]   w_strb;
    logic          b_valid = 1'b0, b_ready;
    logic [1:0]    b_resp = '0;
    logic          ar_valid, ar_ready = 1'b0;
    logic [31:0]   ar_addr;
    logic [7:0]    ar_len;
    logic [2:0]    ar_size;
    logic [1:0]    ar_burst;
    logic          r_valid = 1'b0, r_ready, r_last = 1'b0;
    logic [127:0]  r_data = '0;
    logic [1:0]    r_resp = '0;

    tcp_axi4_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .tcpBus_cmd_valid(cmd_valid), .tcpBus_cmd_ready(cmd_ready),
        .tcpBus_cmd_write(cmd_write), .tcpBus_cmd_addr(cmd_addr), .tcpBus_cmd_size(cmd_size),
        .tcpBus_wdata_valid(wdata_valid), .tcpBus_wdata_ready(wdata_ready),
        .tcpBus_wdata_payload_fragment(wdata_frag), .tcpBus_wdata_payload_last(wdata_last),
        .tcpBus_rdata_valid(rdata_valid), .tcpBus_rdata_ready(rdata_ready),
        .tcpBus_rdata_payload_fragment(rdata_frag), .tcpBus_rdata_payload_last(rdata_last),
        .tcpBus_rsp_valid(rsp_valid), .tcpBus_rsp_ready(rsp_ready), .tcpBus_rsp_payload(rsp_payload),
        .masterAxi_aw_valid(aw_valid), .masterAxi_aw_ready(aw_ready), .masterAxi_aw_addr(aw_addr),
        .masterAxi_aw_len(aw_len), .masterAxi_aw_size(aw_size), .masterAxi_aw_burst(aw_burst),
        .masterAxi_w_valid(w_valid), .masterAxi_w_ready(w_ready), .masterAxi_w_data(w_data),
        .masterAxi_w_strb(w_strb), .masterAxi_w_last(w_last),
        .masterAxi_b_valid(b_valid), .masterAxi_b_ready(b_ready), .masterAxi_b_resp(b_resp),
        .masterAxi_ar_valid(ar_valid), .masterAxi_ar_ready(ar_ready), .masterAxi_ar_addr(ar_addr),
        .masterAxi_ar_len(ar_len), .masterAxi_ar_size(ar_size), .masterAxi_ar_burst(ar_burst),
        .masterAxi_r_valid(r_valid), .masterAxi_r_ready(r_ready), .masterAxi_r_data(r_data),
        .masterAxi_r_resp(r_resp), .masterAxi_r_last(r_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rsp_seen = 0;
    int cmds_done = 0;
    int w_hs_cnt = 0;
    bit bp_en = 1'b0;
    int resp_mode = 0;

    burst_t       exp_aw_q[$];
    burst_t       exp_ar_q[$];
    beat_t        exp_w_q[$];
    beat_t        exp_r_q[$];
    logic [1:0]   exp_rsp_q[$];
    logic [127:0] wdata_q[$];
    logic [1:0]   b_resp_q[$];
    logic [1:0]   r_resp_q[$];

    logic [127:0] ref_mem   [logic [31:0]];
    logic [127:0] slave_mem [logic [31:0]];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got handshake expected none", name);
    endtask

    task automatic abort_run(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Content of never-written memory beats, shared by the model and the slave.
    function automatic logic [127:0] mem_init(input logic [31:0] idx);
        return {idx ^ 32'hA5A5_5A5A, ~idx, idx * 32'd3, idx};
    endfunction

    function automatic logic [127:0] ref_rd(input logic [31:0] idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return mem_init(idx);
    endfunction

    function automatic logic [127:0] slave_rd(input logic [31:0] idx);
        if (slave_mem.exists(idx)) return slave_mem[idx];
        return mem_init(idx);
    endfunction

    function automatic logic [1:0] pick_resp(input int bi);
        if (resp_mode == 2) return (bi == 0) ? 2'b10 : 2'b00;
        if (resp_mode == 1 && $urandom_range(0, 7) == 0) return 2'($urandom_range(1, 3));
        return 2'b00;
    endfunction

    // Reference model: splits the command by the burst rules and queues every expectation.
    task automatic plan_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] size,
                            output logic [31:0] nbeats);
        logic [31:0]  a, left, room, n, ba;
        logic [1:0]   rmax, rc;
        logic [127:0] d;
        burst_t       b;
        beat_t        bt;
        int           bi;
        a = addr & 32'hFFFF_FFF0;
        left = size >> 4;
        nbeats = left;
        rmax = 2'b00;
        bi = 0;
        while (left != 0) begin
            room = (32'd4096 - (a & 32'h0000_0FFF)) / 32'd16;
            n = left;
            if (n > 32'(MB)) n = 32'(MB);
            if (n > room) n = room;
            b.addr = a;
            b.len = 8'(n - 1);
            if (wr) exp_aw_q.push_back(b); else exp_ar_q.push_back(b);
            for (int i = 0; i < int'(n); i++) begin
                ba = a + 32'(i * 16);
                if (wr) begin
                    d = {$urandom, $urandom, $urandom, $urandom};
                    wdata_q.push_back(d);
                    bt.data = d;
                    bt.last = (i == int'(n) - 1);
                    exp_w_q.push_back(bt);
                    ref_mem[ba >> 4] = d;
                end else begin
                    bt.data = ref_rd(ba >> 4);
                    bt.last = (left == n) && (i == int'(n) - 1);
                    exp_r_q.push_back(bt);
                    rc = pick_resp(bi);
                    r_resp_q.push_back(rc);
                    if (rc > rmax) rmax = rc;
                end
            end
            if (wr) begin
                rc = pick_resp(bi);
                b_resp_q.push_back(rc);
                if (rc > rmax) rmax = rc;
            end
            a = a + n * 32'd16;
            left = left - n;
            bi++;
        end
        exp_rsp_q.push_back(rmax);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_rsp_q.size() != 0) begin
            @(posedge clk); #1;
            t++;
            if (t > 5000) abort_run("wait_rsp");
        end
    endtask

    task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] size);
        logic [31:0] nb;
        bit hs;
        int t;
        wait_idle();
        plan_cmd(wr, addr, size, nb);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size;
        hs = 1'b0;
        t = 0;
        while (!hs) begin
            @(negedge clk);
            hs = cmd_valid && cmd_ready;
            @(posedge clk); #1;
            t++;
            if (!hs && t > 2000) abort_run("cmd_accept");
        end
        cmd_valid = 1'b0;
        cmds_done++;
        if (nb == 0) begin
            chk("zero_rsp_next_cycle", rsp_valid, 1);
            chk("zero_no_addr_valid", {aw_valid, ar_valid}, 0);
        end else if (wr) begin
            chk("aw_valid_after_accept", aw_valid, 1);
        end else begin
            chk("ar_valid_after_accept", ar_valid, 1);
        end
    endtask

    // AXI write slave: stores W beats, answers each burst with a queued B code.
    initial begin : slave_wr
        logic aw_hs, w_hs, b_hs, wl, b_pend;
        logic [31:0] aw_a, cur;
        logic [127:0] wd;
        cur = '0;
        b_pend = 1'b0;
        forever begin
            @(negedge clk);
            aw_hs = aw_valid && aw_ready; aw_a = aw_addr;
            w_hs = w_valid && w_ready; wd = w_data; wl = w_last;
            b_hs = b_valid && b_ready;
            @(posedge clk); #1;
            if (reset) begin
                aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00; b_pend = 1'b0;
            end else begin
                if (aw_hs) cur = aw_a;
                if (w_hs) begin
                    slave_mem[cur >> 4] = wd;
                    cur = cur + 32'd16;
                    if (wl) b_pend = 1'b1;
                end
                if (b_hs) b_valid = 1'b0;
                if (b_pend && !b_valid && (!bp_en || $urandom_range(0, 2) == 0)) begin
                    b_valid = 1'b1;
                    b_resp = (b_resp_q.size() > 0) ? b_resp_q.pop_front() : 2'b00;
                    b_pend = 1'b0;
                end
                aw_ready = !bp_en || ($urandom_range(0, 1) == 1);
                w_ready = !bp_en || ($urandom_range(0, 3) != 0);
            end
        end
    end

    // AXI read slave: returns len+1 beats from its memory with queued R codes.
    initial begin : slave_rd_proc
        logic ar_hs, r_hs;
        logic [31:0] ar_a, rd_addr;
        logic [7:0] ar_l;
        int rd_left;
        rd_addr = '0;
        rd_left = 0;
        forever begin
            @(negedge clk);
            ar_hs = ar_valid && ar_ready; ar_a = ar_addr; ar_l = ar_len;
            r_hs = r_valid && r_ready;
            @(posedge clk); #1;
            if (reset) begin
                ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0; rd_left = 0;
            end else begin
                if (ar_hs) begin
                    rd_addr = ar_a;
                    rd_left = int'(ar_l) + 1;
                end
                if (r_hs) begin
                    r_valid = 1'b0;
                    rd_addr = rd_addr + 32'd16;
                    rd_left--;
                end
                if (rd_left > 0 && !r_valid && (!bp_en || $urandom_range(0, 2) != 0)) begin
                    r_valid = 1'b1;
                    r_data = slave_rd(rd_addr >> 4);
                    r_last = (rd_left == 1);
                    r_resp = (r_resp_q.size() > 0) ? r_resp_q.pop_front() : 2'b00;
                end
                ar_ready = !bp_en || ($urandom_range(0, 1) == 1);
            end
        end
    end

    // TCP host side: feeds write beats and applies back-pressure on rdata and rsp.
    initial begin : host_side
        logic whs;
        forever begin
            @(negedge clk);
            whs = wdata_valid && wdata_ready;
            @(posedge clk); #1;
            if (reset) begin
                wdata_valid = 1'b0;
            end else begin
                if (whs) begin
                    wdata_valid = 1'b0;
                    if (wdata_q.size() > 0) void'(wdata_q.pop_front());
                end
                if (!wdata_valid && wdata_q.size() > 0 && (!bp_en || $urandom_range(0, 3) != 0)) begin
                    wdata_valid = 1'b1;
                    wdata_frag = wdata_q[0];
                    wdata_last = (wdata_q.size() == 1);
                end
            end
            rdata_ready = !bp_en || ($urandom_range(0, 2) != 0);
            rsp_ready = !bp_en || ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: every handshake on the DUT outputs pops and compares one expectation.
    initial begin : monitor
        burst_t eb;
        beat_t  et;
        logic [1:0] er;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (aw_valid && aw_ready) begin
                    if (exp_aw_q.size() == 0) note_unexpected("aw_extra");
                    else begin
                        eb = exp_aw_q.pop_front();
                        chk("aw_addr", aw_addr, eb.addr);
                        chk("aw_len", aw_len, eb.len);
                        chk("aw_size_burst", {aw_size, aw_burst}, {3'd4, 2'b01});
                    end
                end
                if (ar_valid && ar_ready) begin
                    if (exp_ar_q.size() == 0) note_unexpected("ar_extra");
                    else begin
                        eb = exp_ar_q.pop_front();
                        chk("ar_addr", ar_addr, eb.addr);
                        chk("ar_len", ar_len, eb.len);
                        chk("ar_size_burst", {ar_size, ar_burst}, {3'd4, 2'b01});
                    end
                end
                if (w_valid && w_ready) begin
                    w_hs_cnt++;
                    if (exp_w_q.size() == 0) note_unexpected("w_extra");
                    else begin
                        et = exp_w_q.pop_front();
                        chk("w_data", w_data, et.data);
                        chk("w_last", w_last, et.last);
                        chk("w_strb", w_strb, 16'hFFFF);
                    end
                end
                if (rdata_valid && rdata_ready) begin
                    if (exp_r_q.size() == 0) note_unexpected("rdata_extra");
                    else begin
                        et = exp_r_q.pop_front();
                        chk("rdata_fragment", rdata_frag, et.data);
                        chk("rdata_last", rdata_last, et.last);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    rsp_seen++;
                    if (exp_rsp_q.size() == 0) note_unexpected("rsp_extra");
                    else begin
                        er = exp_rsp_q.pop_front();
                        chk("rsp_payload", rsp_payload, er);
                    end
                end
            end
        end
    end

    initial begin : main
        int t;
        int base;
        logic [31:0] ra, rs;
        bit rw;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {aw_valid, ar_valid, w_valid, rdata_valid, rsp_valid, wdata_ready}, 0);
        chk("rst_readies", {b_ready, r_ready}, 0);
        chk("rst_aw_fields", {aw_addr, aw_len, aw_size}, 0);
        chk("rst_ar_fields", {ar_addr, ar_len, ar_size}, 0);
        chk("rst_rsp_rlast", {rsp_payload, rdata_last}, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // Directed cases, no back-pressure.
        bp_en = 1'b0;
        resp_mode = 0;
        do_cmd(1'b1, 32'h0000_0FE0, 32'd64);
        do_cmd(1'b0, 32'h0000_0100, 32'd512);
        resp_mode = 2;
        do_cmd(1'b1, 32'h0000_2000, 32'd512);
        resp_mode = 0;
        do_cmd(1'b1, 32'h0000_0040, 32'd8);
        do_cmd(1'b1, 32'hFFFF_FFE0, 32'd64);
        do_cmd(1'b0, 32'hFFFF_FFE0, 32'd64);
        do_cmd(1'b0, 32'h0000_0FE0, 32'd64);

        // Random mixed traffic with back-pressure everywhere.
        bp_en = 1'b1;
        resp_mode = 1;
        for (int k = 0; k < 200; k++) begin
            rw = ($urandom_range(0, 1) == 1);
            ra = 32'($urandom_range(0, 32'h3FFF));
            rs = 32'($urandom_range(0, 32) * 16);
            if ($urandom_range(0, 3) == 0) rs = rs + 32'($urandom_range(1, 15));
            do_cmd(rw, ra, rs);
        end

        // Reset in the middle of a write burst.
        wait_idle();
        bp_en = 1'b0;
        resp_mode = 0;
        base = w_hs_cnt;
        do_cmd(1'b1, 32'h8000_0000, 32'd256);
        t = 0;
        while (w_hs_cnt < base + 2) begin
            @(posedge clk); #1;
            t++;
            if (t > 1000) abort_run("reach_wr_data");
        end
        reset = 1'b1;
        exp_aw_q.delete(); exp_ar_q.delete(); exp_w_q.delete(); exp_r_q.delete();
        exp_rsp_q.delete(); wdata_q.delete(); b_resp_q.delete(); r_resp_q.delete();
        cmds_done--;
        @(posedge clk); #1;
        chk("mid_reset_valids", {aw_valid, ar_valid, w_valid, rdata_valid, rsp_valid, cmd_ready}, 0);
        chk("mid_reset_readies", {b_ready, r_ready, wdata_ready}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("cmd_ready_after_mid_reset", cmd_ready, 1);
        do_cmd(1'b1, 32'h8000_1000, 32'd48);
        do_cmd(1'b0, 32'h8000_1000, 32'd48);

        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("rsp_count", rsp_seen, cmds_done);
        chk("aw_ar_left", exp_aw_q.size() + exp_ar_q.size(), 0);
        chk("w_r_left", exp_w_q.size() + exp_r_q.size(), 0);
        chk("wdata_left", wdata_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
